dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_controller.sv | 100 ++++++++++
 tb/tb_dcache_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back/write-allocate data cache with a single-line memory port
module dcache_controller #(
  parameter int NUM_SETS     = 16,
  parameter bit MEM_LAT_HOLD = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 27 - IW;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t state, state_n;
  logic first;
  logic [26:0] miss_line;
  logic [NUM_SETS-1:0] valid, dirty;
  logic [TW-1:0] tags [NUM_SETS];
  logic [255:0] lines [NUM_SETS];
  logic [IW-1:0] idx, m_idx;
  logic [TW-1:0] tag;
  logic [2:0] word;
  logic req, hit, wr_hit, fill, unused_addr;
  assign idx         = cpu_addr_i[5 +: IW];
  assign tag         = cpu_addr_i[31 -: TW];
  assign word        = cpu_addr_i[4:2];
  assign m_idx       = miss_line[IW-1:0];
  assign unused_addr = ^cpu_addr_i[1:0];
  assign req         = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit         = valid[idx] && tags[idx] == tag;
  assign wr_hit      = state == IDLE && cpu_MemWrite_i && hit;
  assign fill        = state == REFILL && mem_ack_i;
  assign cpu_stall_o = req && (state != IDLE || !hit);
  assign cpu_data_o  = (state == IDLE && cpu_MemRead_i && !cpu_MemWrite_i && hit) ? lines[idx][{word, 5'b0} +: 32] : '0;
  assign mem_enable_o = state != IDLE && (MEM_LAT_HOLD || first);
  // Next state and memory-side request; the miss address is latched so a dropped request still completes
  always_comb begin
    state_n     = state;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    case (state)
      IDLE:      if (req && !hit) state_n = (valid[idx] && dirty[idx]) ? WRITEBACK : REFILL;
      WRITEBACK: begin
        mem_write_o = 1'b1;
        mem_addr_o  = {tags[m_idx], m_idx, 5'b0};
        mem_data_o  = lines[m_idx];
        if (mem_ack_i) state_n = REFILL;
      end
      REFILL: begin
        mem_addr_o = {miss_line, 5'b0};
        if (mem_ack_i) state_n = IDLE;
      end
      default:   state_n = IDLE;
    endcase
  end
  // State register, first-cycle marker for pulsed enables, and miss line address capture while idle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      first     <= 1'b0;
      miss_line <= '0;
    end else begin
      state <= state_n;
      first <= state_n != state;
      if (state == IDLE) miss_line <= cpu_addr_i[31:5];
    end
  end
  // Valid/dirty bookkeeping: refill installs a clean line, a write hit dirties it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      valid[m_idx] <= 1'b1;
      dirty[m_idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty[idx] <= 1'b1;
    end
  end
  // Tag and line storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tags[m_idx]  <= miss_line[26 -: TW];
      lines[m_idx] <= mem_data_i;
    end else if (wr_hit) begin
      lines[idx][{word, 5'b0} +: 32] <= cpu_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized and directed checks of dcache_controller against a line-level cache/memory model
module tb_dcache_controller;
  logic clk_i = 1'b0, rst_i = 1'b1, rd = 1'b0, wr = 1'b0, ack = 1'b0;
  logic [31:0] addr = '0, din = '0;
  logic [255:0] mdi = '0;
  logic [31:0] cpu_data_o, mem_addr_o;
  logic cpu_stall_o, mem_enable_o, mem_write_o;
  logic [255:0] mem_data_o;
  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr),
    .cpu_addr_i(addr), .cpu_data_i(din), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mdi), .mem_ack_i(ack)
  );
  always #5 clk_i = ~clk_i;
  logic chk = 1'b0, e_stall = 1'b0, e_en = 1'b0, e_wr = 1'b0;
  logic [31:0] e_data = '0, e_addr = '0;
  logic [255:0] e_wd = '0;
  int n_tests = 0, n_fail = 0;
  logic mv [16], md [16];
  logic [22:0] mt [16];
  logic [255:0] ml [16];
  logic [255:0] mem [logic [26:0]];
  logic [255:0] l0, l1, l2, l3, l4, l5;
  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic cmp(input string n, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, got, exp);
    end
  endtask
  always @(negedge clk_i) if (chk) begin
    cmp("stall", 256'(cpu_stall_o), 256'(e_stall));
    cmp("cpu_data", 256'(cpu_data_o), 256'(e_data));
    cmp("mem_en", 256'(mem_enable_o), 256'(e_en));
    cmp("mem_wr", 256'(mem_write_o), 256'(e_wr));
    cmp("mem_addr", 256'(mem_addr_o), 256'(e_addr));
    cmp("mem_wdata", mem_data_o, e_wd);
  end
  task automatic cyc(input logic r, w, input logic [31:0] a, d, input logic k, input logic [255:0] m,
                     input logic es, input logic [31:0] edat, input logic een, ewr,
                     input logic [31:0] ea, input logic [255:0] ewd);
    rd = r; wr = w; addr = a; din = d; ack = k; mdi = m;
    e_stall = es; e_data = edat; e_en = een; e_wr = ewr; e_addr = ea; e_wd = ewd; chk = 1'b1;
    @(posedge clk_i); #1;
  endtask
  task automatic get_line(input logic [26:0] la, output logic [255:0] l);
    if (!mem.exists(la)) mem[la] = rnd256();
    l = mem[la];
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
  endtask
  task automatic model_fill(input int i, input logic [22:0] t, input logic [255:0] l);
    mv[i] = 1'b1; md[i] = 1'b0; mt[i] = t; ml[i] = l;
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), rnd256(), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
  endtask
  task automatic access(input logic r, w, input logic [31:0] a, d, input int dmax);
    logic [3:0] i;
    logic [22:0] t;
    logic [2:0] wd;
    logic [31:0] va, ra;
    logic [255:0] l;
    int dl;
    i = a[8:5]; t = a[31:9]; wd = a[4:2];
    if (!(mv[i] && mt[i] == t)) begin
      cyc(r, w, a, d, 1'($urandom_range(0, 1)), rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
      if (mv[i] && md[i]) begin
        va = {mt[i], i, 5'b0};
        dl = $urandom_range(0, dmax);
        for (int k = 0; k <= dl; k++) cyc(r, w, a, d, k == dl, rnd256(), 1'b1, 32'h0, 1'b1, 1'b1, va, ml[i]);
        mem[va[31:5]] = ml[i];
      end
      ra = {t, i, 5'b0};
      get_line(ra[31:5], l);
      dl = $urandom_range(0, dmax);
      for (int k = 0; k <= dl; k++) cyc(r, w, a, d, k == dl, (k == dl) ? l : rnd256(), 1'b1, 32'h0, 1'b1, 1'b0, ra, '0);
      model_fill(i, t, l);
    end
    cyc(r, w, a, d, 1'($urandom_range(0, 1)), rnd256(), 1'b0, (r && !w) ? ml[i][wd*32 +: 32] : 32'h0, 1'b0, 1'b0, 32'h0, '0);
    if (w) begin ml[i][wd*32 +: 32] = d; md[i] = 1'b1; end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end
  initial begin
    model_reset();
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    cyc(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, rnd256(), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    rst_i = 1'b1;
    l0 = rnd256(); l0[31:0] = 32'hDEAD_BEEF; mem[27'h2] = l0;
    cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rnd256(), 1'b1, 32'h0, 1'b1, 1'b0, 32'h40, '0);
    cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, l0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h40, '0);
    cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rnd256(), 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, '0);
    model_fill(2, 23'h0, l0);
    cyc(1'b0, 1'b1, 32'h44, 32'h1234_5678, 1'b0, rnd256(), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    ml[2][63:32] = 32'h1234_5678; md[2] = 1'b1;
    cyc(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, rnd256(), 1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0, '0);
    l1 = l0; l1[63:32] = 32'h1234_5678;
    l2 = rnd256(); mem[27'h12] = l2;
    cyc(1'b1, 1'b0, 32'h240, 32'h0, 1'b0, rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    cyc(1'b1, 1'b0, 32'h240, 32'h0, 1'b1, rnd256(), 1'b1, 32'h0, 1'b1, 1'b1, 32'h40, l1);
    cyc(1'b1, 1'b0, 32'h240, 32'h0, 1'b1, l2, 1'b1, 32'h0, 1'b1, 1'b0, 32'h240, '0);
    cyc(1'b1, 1'b0, 32'h240, 32'h0, 1'b0, rnd256(), 1'b0, l2[31:0], 1'b0, 1'b0, 32'h0, '0);
    mem[27'h2] = l1; model_fill(2, 23'h1, l2);
    access(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 2);
    cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, rnd256(), 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, '0);
    access(1'b1, 1'b0, 32'h280, 32'h0, 1);
    get_line(27'hF, l3);
    cyc(1'b1, 1'b0, 32'h1E0, 32'h0, 1'b0, rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 32'h1E0, 32'h0, k == 9, (k == 9) ? l3 : rnd256(), 1'b1, 32'h0, 1'b1, 1'b0, 32'h1E0, '0);
    cyc(1'b1, 1'b0, 32'h1E0, 32'h0, 1'b0, rnd256(), 1'b0, l3[31:0], 1'b0, 1'b0, 32'h0, '0);
    model_fill(15, 23'h0, l3);
    cyc(1'b1, 1'b0, 32'h180, 32'h0, 1'b0, rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    cyc(1'b1, 1'b0, 32'h180, 32'h0, 1'b0, rnd256(), 1'b1, 32'h0, 1'b1, 1'b0, 32'h180, '0);
    rst_i = 1'b0;
    cyc(1'b1, 1'b0, 32'h180, 32'h0, 1'b1, rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    rst_i = 1'b1; model_reset();
    cyc(1'b1, 1'b0, 32'h180, 32'h0, 1'b1, rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    get_line(27'hC, l4);
    cyc(1'b1, 1'b0, 32'h180, 32'h0, 1'b0, rnd256(), 1'b1, 32'h0, 1'b1, 1'b0, 32'h180, '0);
    cyc(1'b1, 1'b0, 32'h180, 32'h0, 1'b1, l4, 1'b1, 32'h0, 1'b1, 1'b0, 32'h180, '0);
    cyc(1'b1, 1'b0, 32'h180, 32'h0, 1'b0, rnd256(), 1'b0, l4[31:0], 1'b0, 1'b0, 32'h0, '0);
    model_fill(12, 23'h0, l4);
    get_line(27'h1D, l5);
    cyc(1'b1, 1'b0, 32'h3A0, 32'h0, 1'b0, rnd256(), 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    cyc(1'b0, 1'b0, $urandom, 32'h0, 1'b0, rnd256(), 1'b0, 32'h0, 1'b1, 1'b0, 32'h3A0, '0);
    cyc(1'b0, 1'b0, $urandom, 32'h0, 1'b1, l5, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3A0, '0);
    cyc(1'b0, 1'b0, 32'h3A0, 32'h0, 1'b0, rnd256(), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
    cyc(1'b1, 1'b0, 32'h3A0, 32'h0, 1'b0, rnd256(), 1'b0, l5[31:0], 1'b0, 1'b0, 32'h0, '0);
    model_fill(13, 23'h1, l5);
    repeat (400) begin
      if ($urandom_range(0, 4) == 0) idle();
      else begin
        int op;
        op = $urandom_range(0, 2);
        access(op != 1, op != 0, {23'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))}, $urandom, 3);
      end
    end
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
